// File: rtl/tw_gen.sv
// Twiddle-factor generator for radix-2 SDF FFT stages: quarter-wave cosine table,
// direct-address port plus per-stage sequencer. Define TW_INV_EN for conjugated (inverse) twiddles.
module tw_gen #(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned TW_W  = 12,
  localparam int unsigned SW   = $clog2(LOG2N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   addr_valid,
  input  logic [LOG2N-1:0]       addr,
  output logic                   addr_ready,
  input  logic                   seq_start,
  input  logic [SW-1:0]          seq_stage,
  output logic                   seq_busy,
  output logic                   seq_done,
`ifdef TW_INV_EN
  input  logic                   inv,
`endif
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic signed [TW_W-1:0] twiddle_re,
  output logic signed [TW_W-1:0] twiddle_im
);

  localparam int unsigned N   = 1 << LOG2N;
  localparam int unsigned Q   = N / 4;
  localparam int unsigned AMP = (1 << (TW_W - 1)) - 1;
  localparam int unsigned RW  = LOG2N - 2;
  localparam int unsigned IW  = LOG2N - 1;
  localparam int unsigned JW  = LOG2N - 1;

  // round(AMP*cos(2*pi*r/N)) by Taylor series; angle never exceeds pi/2
  function automatic int cos_q(input int unsigned r);
    real x;
    real term;
    real sum;
    x    = 2.0 * 3.14159265358979323846 * real'(r) / real'(N);
    sum  = 1.0;
    term = 1.0;
    for (int n = 1; n <= 20; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return int'(real'(AMP) * sum);
  endfunction

  logic signed [TW_W-1:0] ctab [Q+1];

  for (genvar i = 0; i <= Q; i++) begin : g_tab
    localparam int CV = cos_q(i);
    assign ctab[i] = TW_W'(CV);
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d, s_clamp;
  logic [JW-1:0]     j_q, j_d, j_last;
  logic              ce, run, seq_issue, dir_acc, req_v;
  logic [LOG2N-1:0]  req_k, seq_k;
  logic [1:0]        q_in;
  logic [IW-1:0]     ridx, cidx;

  logic                   v1;
  logic [1:0]             q1;
  logic signed [TW_W-1:0] ca1, cb1;
  logic signed [TW_W-1:0] re_n, im_n;
`ifdef TW_INV_EN
  logic                   inv1;
`endif

  assign ce         = out_ready | ~out_valid;
  assign run        = (state_q == S_RUN);
  assign seq_busy   = run;
  // a start pulse in idle takes priority over a concurrent direct request
  assign addr_ready = rst & ce & ~run & ~seq_start;
  assign dir_acc    = addr_valid & addr_ready;

  assign s_clamp   = ({1'b0, seq_stage} >= (SW+1)'(LOG2N)) ? SW'(LOG2N - 1) : seq_stage;
  // last j = N/2^(s+1) - 1, i.e. the all-ones j pattern shifted down by s
  assign j_last    = {JW{1'b1}} >> s_q;
  assign seq_k     = LOG2N'({1'b0, j_q} << s_q);
  assign seq_issue = run & ce;
  assign seq_done  = rst & seq_issue & (j_q == j_last);

  assign req_v = seq_issue | dir_acc;
  assign req_k = run ? seq_k : addr;
  assign q_in  = req_k[LOG2N-1 -: 2];
  assign ridx  = {1'b0, req_k[RW-1:0]};
  assign cidx  = IW'(Q) - ridx;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
    end
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          state_d = S_RUN;
          s_d     = s_clamp;
          j_d     = '0;
        end
      end
      S_RUN: begin
        if (ce) begin
          j_d = j_q + 1'b1;
          if (j_q == j_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 1: quadrant and both table reads
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1  <= 1'b0;
      q1  <= '0;
      ca1 <= '0;
      cb1 <= '0;
`ifdef TW_INV_EN
      inv1 <= 1'b0;
`endif
    end else if (ce) begin
      v1 <= req_v;
      if (req_v) begin
        q1  <= q_in;
        ca1 <= ctab[ridx];
        cb1 <= ctab[cidx];
`ifdef TW_INV_EN
        inv1 <= inv;
`endif
      end
    end
  end

  // Quadrant sign/swap; ca1=C[r], cb1=C[Q-r]
  always_comb begin
    re_n = ca1;
    im_n = -cb1;
    case (q1)
      2'd0: begin re_n = ca1;  im_n = -cb1; end
      2'd1: begin re_n = -cb1; im_n = -ca1; end
      2'd2: begin re_n = -ca1; im_n = cb1;  end
      2'd3: begin re_n = cb1;  im_n = ca1;  end
      default: ;
    endcase
`ifdef TW_INV_EN
    if (inv1) im_n = -im_n;
`endif
  end

  // Stage 2: output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      twiddle_re <= '0;
      twiddle_im <= '0;
    end else if (ce) begin
      out_valid <= v1;
      if (v1) begin
        twiddle_re <= re_n;
        twiddle_im <= im_n;
      end
    end
  end

endmodule

// File: tb/tb_tw_gen.sv
// Directed self-checking bench for tw_gen: LOG2N=3 instance for the main scenarios,
// LOG2N=5 instance for table spot checks and reset mid-sequence.
module tb_tw_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic              rst, addr_valid, addr_ready, seq_start, seq_busy, seq_done;
  logic              out_ready, out_valid;
  logic [2:0]        addr;
  logic [1:0]        seq_stage;
  logic signed [11:0] tw_re, tw_im;

  logic              rst5, addr_valid5, addr_ready5, seq_start5, seq_busy5, seq_done5;
  logic              out_ready5, out_valid5;
  logic [4:0]        addr5;
  logic [2:0]        seq_stage5;
  logic signed [11:0] tw_re5, tw_im5;
`ifdef TW_INV_EN
  logic              inv, inv5;
`endif

  tw_gen #(.LOG2N(3), .TW_W(12)) dut (
    .clk(clk), .rst(rst), .addr_valid(addr_valid), .addr(addr), .addr_ready(addr_ready),
    .seq_start(seq_start), .seq_stage(seq_stage), .seq_busy(seq_busy), .seq_done(seq_done),
`ifdef TW_INV_EN
    .inv(inv),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .twiddle_re(tw_re), .twiddle_im(tw_im)
  );

  tw_gen #(.LOG2N(5), .TW_W(12)) dut5 (
    .clk(clk), .rst(rst5), .addr_valid(addr_valid5), .addr(addr5), .addr_ready(addr_ready5),
    .seq_start(seq_start5), .seq_stage(seq_stage5), .seq_busy(seq_busy5), .seq_done(seq_done5),
`ifdef TW_INV_EN
    .inv(inv5),
`endif
    .out_ready(out_ready5), .out_valid(out_valid5), .twiddle_re(tw_re5), .twiddle_im(tw_im5)
  );

  task automatic idle(input int n);
    addr_valid = 1'b0;
    seq_start  = 1'b0;
    out_ready  = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rst5 = 1'b0;
    addr_valid = 1'b1; addr = 3'd5; seq_start = 1'b1; seq_stage = 2'd1; out_ready = 1'b1;
    addr_valid5 = 1'b0; addr5 = '0; seq_start5 = 1'b0; seq_stage5 = '0; out_ready5 = 1'b1;
`ifdef TW_INV_EN
    inv = 1'b1; inv5 = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", i, out_valid); end
      tests++; if (tw_re !== 12'sd0) begin fails++; $display("FAIL reset_re cyc%0d: got %0d want 0", i, tw_re); end
      tests++; if (tw_im !== 12'sd0) begin fails++; $display("FAIL reset_im cyc%0d: got %0d want 0", i, tw_im); end
      tests++; if (seq_busy !== 1'b0) begin fails++; $display("FAIL reset_busy cyc%0d: got %b want 0", i, seq_busy); end
      tests++; if (addr_ready !== 1'b0) begin fails++; $display("FAIL reset_addr_ready cyc%0d: got %b want 0", i, addr_ready); end
    end
    rst = 1'b1; rst5 = 1'b1;
`ifdef TW_INV_EN
    inv = 1'b0;
`endif
    idle(3);
  endtask

  task automatic test_direct;
    int exp_re[8] = '{2047, 1447, 0, -1447, -2047, -1447, 0, 1447};
    int exp_im[8] = '{0, -1447, -2047, -1447, 0, 1447, 2047, 1447};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i >= 2) begin
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL direct_valid k=%0d: got %b want 1", i-2, out_valid); end
        tests++; if (tw_re !== 12'(exp_re[i-2])) begin fails++; $display("FAIL direct_re k=%0d: got %0d want %0d", i-2, tw_re, exp_re[i-2]); end
        tests++; if (tw_im !== 12'(exp_im[i-2])) begin fails++; $display("FAIL direct_im k=%0d: got %0d want %0d", i-2, tw_im, exp_im[i-2]); end
      end
      if (i < 8) begin
        addr_valid = 1'b1; addr = 3'(i);
        #1;
        tests++; if (addr_ready !== 1'b1) begin fails++; $display("FAIL direct_ready k=%0d: got %b want 1", i, addr_ready); end
      end else begin
        addr_valid = 1'b0;
      end
    end
    idle(3);
  endtask

  // stage 1 -> k = 0, 2; stage 3 (out of range) behaves as stage 2 -> k = 0 only
  task automatic test_seq(input logic [1:0] stage);
    int ebusy[5]; int edone[5]; int eov[5]; int ere[5]; int eim[5];
    if (stage == 2'd1) begin
      ebusy = '{1, 1, 0, 0, 0}; edone = '{0, 1, 0, 0, 0}; eov = '{0, 0, 1, 1, 0};
      ere   = '{0, 0, 2047, 0, 0}; eim = '{0, 0, 0, -2047, 0};
    end else begin
      ebusy = '{1, 0, 0, 0, 0}; edone = '{1, 0, 0, 0, 0}; eov = '{0, 0, 1, 0, 0};
      ere   = '{0, 0, 2047, 0, 0}; eim = '{0, 0, 0, 0, 0};
    end
    seq_start = 1'b1; seq_stage = stage;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seq_start = 1'b0;
      tests++; if (seq_busy !== 1'(ebusy[i])) begin fails++; $display("FAIL seq%0d_busy cyc%0d: got %b want %0d", stage, i+1, seq_busy, ebusy[i]); end
      tests++; if (seq_done !== 1'(edone[i])) begin fails++; $display("FAIL seq%0d_done cyc%0d: got %b want %0d", stage, i+1, seq_done, edone[i]); end
      tests++; if (out_valid !== 1'(eov[i])) begin fails++; $display("FAIL seq%0d_valid cyc%0d: got %b want %0d", stage, i+1, out_valid, eov[i]); end
      if (eov[i] == 1) begin
        tests++; if (tw_re !== 12'(ere[i]) || tw_im !== 12'(eim[i])) begin fails++;
          $display("FAIL seq%0d_data cyc%0d: got (%0d,%0d) want (%0d,%0d)", stage, i+1, tw_re, tw_im, ere[i], eim[i]); end
      end
    end
    idle(2);
  endtask

  task automatic test_stall;
    addr_valid = 1'b1; addr = 3'd1; out_ready = 1'b0;
    @(posedge clk); #1;
    addr_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid cyc%0d: got %b want 1", i, out_valid); end
      tests++; if (tw_re !== 12'sd1447 || tw_im !== -12'sd1447) begin fails++;
        $display("FAIL stall_data cyc%0d: got (%0d,%0d) want (1447,-1447)", i, tw_re, tw_im); end
      tests++; if (addr_ready !== 1'b0) begin fails++; $display("FAIL stall_ready cyc%0d: got %b want 0", i, addr_ready); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (addr_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b want 1", addr_ready); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_drain_valid: got %b want 0", out_valid); end
    idle(2);
  endtask

  task automatic test_priority;
    seq_start = 1'b1; seq_stage = 2'd1; addr_valid = 1'b1; addr = 3'd3; out_ready = 1'b1;
    #1;
    tests++; if (addr_ready !== 1'b0) begin fails++; $display("FAIL prio_ready_start: got %b want 0", addr_ready); end
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      seq_start = 1'b0;
      if (i == 4) begin
        addr_valid = 1'b0;
        tests++; if (tw_re !== 12'sd0 || tw_im !== -12'sd2047) begin fails++;
          $display("FAIL prio_seq_k2: got (%0d,%0d) want (0,-2047)", tw_re, tw_im); end
      end
      if (i == 5) begin
        tests++; if (out_valid !== 1'b1 || tw_re !== -12'sd1447 || tw_im !== -12'sd1447) begin fails++;
          $display("FAIL prio_direct_k3: got v=%b (%0d,%0d) want v=1 (-1447,-1447)", out_valid, tw_re, tw_im); end
      end
      #1;
      if (i <= 3) begin
        tests++; if (addr_ready !== (i == 3)) begin fails++; $display("FAIL prio_ready cyc%0d: got %b want %b", i, addr_ready, (i == 3)); end
      end
    end
    idle(2);
  endtask

`ifdef TW_INV_EN
  task automatic test_inv;
    addr_valid = 1'b1; addr = 3'd1; inv = 1'b1;
    @(posedge clk); #1;
    addr_valid = 1'b0; inv = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || tw_re !== 12'sd1447 || tw_im !== 12'sd1447) begin fails++;
      $display("FAIL inv_k1: got v=%b (%0d,%0d) want v=1 (1447,1447)", out_valid, tw_re, tw_im); end
    idle(2);
  endtask
`endif

  task automatic test_reset_midseq;
    seq_start5 = 1'b1; seq_stage5 = 3'd0; out_ready5 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      seq_start5 = 1'b0;
      tests++; if (seq_busy5 !== 1'b1) begin fails++; $display("FAIL mid_busy cyc%0d: got %b want 1", i, seq_busy5); end
      tests++; if (seq_done5 !== 1'b0) begin fails++; $display("FAIL mid_done cyc%0d: got %b want 0", i, seq_done5); end
      if (i == 3) begin
        tests++; if (out_valid5 !== 1'b1 || tw_re5 !== 12'sd2047 || tw_im5 !== 12'sd0) begin fails++;
          $display("FAIL n32_k0: got v=%b (%0d,%0d) want v=1 (2047,0)", out_valid5, tw_re5, tw_im5); end
      end
      if (i == 4) begin
        tests++; if (out_valid5 !== 1'b1 || tw_re5 !== 12'sd2008 || tw_im5 !== -12'sd399) begin fails++;
          $display("FAIL n32_k1: got v=%b (%0d,%0d) want v=1 (2008,-399)", out_valid5, tw_re5, tw_im5); end
      end
    end
    rst5 = 1'b0;
    #1;
    tests++; if (seq_done5 !== 1'b0) begin fails++; $display("FAIL mid_done_in_reset: got %b want 0", seq_done5); end
    @(posedge clk); #1;
    tests++; if (seq_busy5 !== 1'b0) begin fails++; $display("FAIL mid_busy_after_reset: got %b want 0", seq_busy5); end
    tests++; if (out_valid5 !== 1'b0) begin fails++; $display("FAIL mid_valid_after_reset: got %b want 0", out_valid5); end
    rst5 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tests++; if (seq_busy5 !== 1'b0 || seq_done5 !== 1'b0) begin fails++;
        $display("FAIL mid_aborted cyc%0d: got busy=%b done=%b want 0 0", i, seq_busy5, seq_done5); end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_seq(2'd1);
    test_seq(2'd3);
    test_stall();
    test_priority();
`ifdef TW_INV_EN
    test_inv();
`endif
    test_reset_midseq();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
